// File: rtl/census_stream_ctrl_if.sv
// Pixel source handshake and census-unit drive bundle for census_stream_ctrl.
// master = pixel source / census consumer side, slave = the frame sequencer.
interface census_stream_ctrl_if;
   logic [7:0] src_val;
   logic       src_valid;
   logic       src_sof;
   logic       src_ready;
   logic [7:0] cen_val;
   logic [9:0] cen_x;
   logic [9:0] cen_y;
   logic       cen_is_val;
   logic [7:0] cen_thresh;
   logic       cen_reset;

   modport master (
      output src_val, src_valid, src_sof,
      input  src_ready,
      input  cen_val, cen_x, cen_y, cen_is_val, cen_thresh, cen_reset
   );

   modport slave (
      input  src_val, src_valid, src_sof,
      output src_ready,
      output cen_val, cen_x, cen_y, cen_is_val, cen_thresh, cen_reset
   );
endinterface

// File: rtl/census_stream_ctrl.sv
// Frame sequencer for the streaming census unit: numbers incoming pixels,
// flushes the census line buffers at end of frame and reports frame completion.
module census_stream_ctrl #(
   parameter int ROW_SZ    = 320,
   parameter int COL_SZ    = 240,
   parameter int FLUSH_LEN = 2*ROW_SZ+3
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [7:0]          thresh_in,
   input  logic                thresh_we,
   census_stream_ctrl_if.slave bus,
   output logic                frame_done,
   output logic                sof_err,
   output logic                busy,
   output logic [15:0]         frame_cnt
);

   localparam int              FCW    = $clog2(FLUSH_LEN + 1);
   localparam logic [9:0]      X_LAST = 10'(ROW_SZ - 1);
   localparam logic [9:0]      Y_LAST = 10'(COL_SZ - 1);
   localparam logic [FCW-1:0]  F_LAST = FCW'(FLUSH_LEN - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t         state_q, state_d;
   logic [9:0]     x_q, x_d, y_q, y_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;
   logic [7:0]     stg_q, stg_d;
   logic [7:0]     thr_q, thr_d;
   logic [7:0]     val_q, val_d;
   logic [9:0]     cx_q, cx_d, cy_q, cy_d;
   logic           isval_q, isval_d;
   logic           rst_done_q, rst_done_d;
   logic           cen_reset_q, cen_reset_d;
   logic           done_q, done_d;
   logic           err_q, err_d;
   logic           busy_q, busy_d;
   logic [15:0]    cnt_q, cnt_d;
   logic [9:0]     x_adv, y_adv;
   logic           src_ready;
   logic           accept;

   // Ready is held low until the one-cycle census reset has been issued.
   assign src_ready = rst_done_q && ((state_q == IDLE) || (state_q == RUN));
   assign accept    = bus.src_valid && src_ready;

   always_comb begin
      x_adv = x_q + 10'd1;
      y_adv = y_q;
      if (x_q == X_LAST) begin
         x_adv = 10'd0;
         y_adv = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
      end
   end

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      fcnt_d      = fcnt_q;
      stg_d       = thresh_we ? thresh_in : stg_q;
      thr_d       = thr_q;
      val_d       = val_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      isval_d     = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      cnt_d       = cnt_q;
      rst_done_d  = rst_done_q | cen_reset_q;
      cen_reset_d = !rst_done_q && !cen_reset_q;

      unique case (state_q)
         IDLE: begin
            if (accept && bus.src_sof) begin
               val_d   = bus.src_val;
               cx_d    = 10'd0;
               cy_d    = 10'd0;
               isval_d = 1'b1;
               thr_d   = stg_q;
               x_d     = 10'd1;
               y_d     = 10'd0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (accept) begin
               val_d   = bus.src_val;
               isval_d = 1'b1;
               if (bus.src_sof) begin
                  // A new frame start restarts numbering without counting a frame.
                  err_d = 1'b1;
                  cx_d  = 10'd0;
                  cy_d  = 10'd0;
                  thr_d = stg_q;
                  x_d   = 10'd1;
                  y_d   = 10'd0;
               end else begin
                  cx_d = x_q;
                  cy_d = y_q;
                  if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
                     x_d     = 10'd0;
                     y_d     = 10'd0;
                     fcnt_d  = '0;
                     state_d = FLUSH;
                  end else begin
                     x_d = x_adv;
                     y_d = y_adv;
                  end
               end
            end
         end
         FLUSH: begin
            val_d   = 8'd0;
            cx_d    = x_q;
            cy_d    = y_q;
            isval_d = 1'b1;
            x_d     = x_adv;
            y_d     = y_adv;
            fcnt_d  = fcnt_q + 1'b1;
            if (fcnt_q == F_LAST) state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            cnt_d   = cnt_q + 16'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN) || (state_d == FLUSH);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         x_q         <= '0;
         y_q         <= '0;
         fcnt_q      <= '0;
         stg_q       <= '0;
         thr_q       <= '0;
         val_q       <= '0;
         cx_q        <= '0;
         cy_q        <= '0;
         isval_q     <= 1'b0;
         rst_done_q  <= 1'b0;
         cen_reset_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         fcnt_q      <= fcnt_d;
         stg_q       <= stg_d;
         thr_q       <= thr_d;
         val_q       <= val_d;
         cx_q        <= cx_d;
         cy_q        <= cy_d;
         isval_q     <= isval_d;
         rst_done_q  <= rst_done_d;
         cen_reset_q <= cen_reset_d;
         done_q      <= done_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.src_ready  = src_ready;
   assign bus.cen_val    = val_q;
   assign bus.cen_x      = cx_q;
   assign bus.cen_y      = cy_q;
   assign bus.cen_is_val = isval_q;
   assign bus.cen_thresh = thr_q;
   assign bus.cen_reset  = cen_reset_q;
   assign frame_done     = done_q;
   assign sof_err        = err_q;
   assign busy           = busy_q;
   assign frame_cnt      = cnt_q;

endmodule

// File: tb/tb_census_stream_ctrl.sv
// Self-checking bench for census_stream_ctrl on a small 8x6 frame: vector table,
// hand-written corner sequences and random gapped traffic against a pixel-index model.
module tb_census_stream_ctrl;

   localparam int R = 8;
   localparam int C = 6;
   localparam int F = 19;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  thresh_in = 8'd0;
   logic        thresh_we = 1'b0;
   logic        frame_done;
   logic        sof_err;
   logic        busy;
   logic [15:0] frame_cnt;

   census_stream_ctrl_if bus();

   census_stream_ctrl #(.ROW_SZ(R), .COL_SZ(C), .FLUSH_LEN(F)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .thresh_in  (thresh_in),
      .thresh_we  (thresh_we),
      .bus        (bus),
      .frame_done (frame_done),
      .sof_err    (sof_err),
      .busy       (busy),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: frame position kept as a linear pixel / flush index.
   int         m_init, m_mode, m_pix, m_fl, m_cnt;
   logic [7:0] m_stg, m_thr;
   int         e_val, e_x, e_y;
   bit         e_isval, e_rst, e_done, e_err, e_busy;

   typedef struct {
      logic       valid;
      logic       sof;
      logic [7:0] val;
      logic       we;
      logic [7:0] tin;
      logic       e_ready;
      logic       e_rst;
      logic       e_isval;
      logic [9:0] e_x;
      logic [9:0] e_y;
      logic [7:0] e_val;
      logic [7:0] e_thr;
      logic       e_err;
   } vec_t;

   vec_t tbl[7];

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      return ((m_mode == 0) && (m_init == 2)) || (m_mode == 1);
   endfunction

   task automatic model_reset();
      m_init = 0; m_mode = 0; m_pix = 0; m_fl = 0; m_cnt = 0;
      m_stg = 8'd0; m_thr = 8'd0;
      e_val = 0; e_x = 0; e_y = 0;
      e_isval = 0; e_rst = 0; e_done = 0; e_err = 0; e_busy = 0;
   endtask

   task automatic emit(input int v, input int x, input int y);
      e_isval = 1; e_val = v; e_x = x; e_y = y;
   endtask

   task automatic model_step(input bit v, input bit s, input logic [7:0] val,
                             input bit we, input logic [7:0] tin);
      bit acc;
      acc = v && m_ready();
      e_isval = 0; e_rst = 0; e_done = 0; e_err = 0;
      if (m_init == 0) begin
         e_rst = 1;
         m_init = 1;
      end else if (m_init == 1) begin
         m_init = 2;
      end
      case (m_mode)
         0: if (acc && s) begin
               emit(int'(val), 0, 0);
               m_thr = m_stg; m_pix = 1; m_mode = 1;
            end
         1: if (acc) begin
               if (s) begin
                  e_err = 1;
                  emit(int'(val), 0, 0);
                  m_thr = m_stg; m_pix = 1;
               end else begin
                  emit(int'(val), m_pix % R, m_pix / R);
                  m_pix++;
                  if (m_pix == R*C) begin
                     m_mode = 2; m_fl = 0;
                  end
               end
            end
         2: begin
               emit(0, m_fl % R, m_fl / R);
               m_fl++;
               if (m_fl == F) m_mode = 3;
            end
         default: begin
               e_done = 1;
               m_cnt = (m_cnt + 1) % 65536;
               m_mode = 0;
            end
      endcase
      if (we) m_stg = tin;
      e_busy = (m_mode == 1) || (m_mode == 2);
   endtask

   task automatic checkOutput();
      cmp("src_ready",  32'(bus.src_ready),  32'(m_ready()));
      cmp("cen_is_val", 32'(bus.cen_is_val), 32'(e_isval));
      cmp("cen_reset",  32'(bus.cen_reset),  32'(e_rst));
      cmp("cen_thresh", 32'(bus.cen_thresh), 32'(m_thr));
      cmp("frame_done", 32'(frame_done),     32'(e_done));
      cmp("sof_err",    32'(sof_err),        32'(e_err));
      cmp("busy",       32'(busy),           32'(e_busy));
      cmp("frame_cnt",  32'(frame_cnt),      32'(m_cnt));
      if (e_isval) begin
         cmp("cen_val", 32'(bus.cen_val), 32'(e_val));
         cmp("cen_x",   32'(bus.cen_x),   32'(e_x));
         cmp("cen_y",   32'(bus.cen_y),   32'(e_y));
      end
   endtask

   task automatic applyStimulus(input bit v, input bit s, input logic [7:0] val,
                                input bit we, input logic [7:0] tin);
      bus.src_valid = v;
      bus.src_sof   = s;
      bus.src_val   = val;
      thresh_we     = we;
      thresh_in     = tin;
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_step(v, s, val, we, tin);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      model_reset();
      repeat (3) applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
      reset_n = 1'b1;
   endtask

   function automatic logic [7:0] rnd_pix();
      return 8'($urandom_range(1, 255));
   endfunction

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int  real_n, fl_n, rst_cnt, last_x, last_y, last_iv_cyc, done_cyc, post_n;
      bit  sof_pending, done_seen, acc;

      bus.src_valid = 1'b0;
      bus.src_sof   = 1'b0;
      bus.src_val   = 8'd0;

      tbl[0] = '{1'b1, 1'b0, 8'h11, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 10'd0, 10'd0, 8'h00, 8'h00, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 8'h00, 8'h00, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 8'h33, 1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 10'd0, 10'd0, 8'h33, 8'h00, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 8'h44, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 10'd1, 10'd0, 8'h44, 8'h00, 1'b0};
      tbl[4] = '{1'b0, 1'b0, 8'h99, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0, 8'h00, 8'h00, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 10'd2, 10'd0, 8'h55, 8'h00, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 8'h66, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 10'd0, 10'd0, 8'h66, 8'h10, 1'b1};

      // Full frame with valid held high and SOF on the first accepted pixel.
      doReset();
      real_n = 0; fl_n = 0; rst_cnt = 0; last_x = -1; last_y = -1;
      last_iv_cyc = -1; done_cyc = -1; sof_pending = 1; done_seen = 0;
      for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
         acc = m_ready();
         applyStimulus(1'b1, sof_pending, rnd_pix(), 1'b0, 8'd0);
         if (acc) sof_pending = 0;
         if (bus.cen_reset) rst_cnt++;
         if (bus.cen_is_val) begin
            if (bus.cen_val != 8'd0) real_n++;
            else fl_n++;
            last_x = int'(bus.cen_x);
            last_y = int'(bus.cen_y);
            last_iv_cyc = cyc;
         end
         if (frame_done) begin
            done_seen = 1;
            done_cyc = cyc;
         end
      end
      cmp("ff_done_seen",      32'(done_seen),   32'd1);
      cmp("ff_reset_cycles",   32'(rst_cnt),     32'd1);
      cmp("ff_real_pixels",    32'(real_n),      32'd48);
      cmp("ff_flush_pixels",   32'(fl_n),        32'd19);
      cmp("ff_last_flush_x",   32'(last_x),      32'd2);
      cmp("ff_last_flush_y",   32'(last_y),      32'd2);
      cmp("ff_done_latency",   32'(done_cyc - last_iv_cyc), 32'd1);
      cmp("ff_frame_cnt",      32'(frame_cnt),   32'd1);

      // Non-SOF pixels in IDLE are swallowed; the next SOF starts at (0,0).
      for (int i = 0; i < 5; i++) begin
         cmp("garbage_ready", 32'(bus.src_ready), 32'd1);
         applyStimulus(1'b1, 1'b0, rnd_pix(), 1'b0, 8'd0);
         cmp("garbage_no_val", 32'(bus.cen_is_val), 32'd0);
      end
      applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0, 8'd0);
      cmp("garbage_sof_val", 32'(bus.cen_is_val), 32'd1);
      cmp("garbage_sof_x",   32'(bus.cen_x),      32'd0);
      cmp("garbage_sof_y",   32'(bus.cen_y),      32'd0);

      // Vector table: reset pulse, SOF timing and threshold staging.
      doReset();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(tbl[i].valid, tbl[i].sof, tbl[i].val, tbl[i].we, tbl[i].tin);
         cmp($sformatf("tbl%0d_ready", i),  32'(bus.src_ready),  32'(tbl[i].e_ready));
         cmp($sformatf("tbl%0d_rst", i),    32'(bus.cen_reset),  32'(tbl[i].e_rst));
         cmp($sformatf("tbl%0d_isval", i),  32'(bus.cen_is_val), 32'(tbl[i].e_isval));
         cmp($sformatf("tbl%0d_thr", i),    32'(bus.cen_thresh), 32'(tbl[i].e_thr));
         cmp($sformatf("tbl%0d_err", i),    32'(sof_err),        32'(tbl[i].e_err));
         if (tbl[i].e_isval) begin
            cmp($sformatf("tbl%0d_x", i),   32'(bus.cen_x),      32'(tbl[i].e_x));
            cmp($sformatf("tbl%0d_y", i),   32'(bus.cen_y),      32'(tbl[i].e_y));
            cmp($sformatf("tbl%0d_val", i), 32'(bus.cen_val),    32'(tbl[i].e_val));
         end
      end

      // Mid-frame SOF at pixel (3,2), then the restarted frame runs to completion.
      for (int i = 0; i < 100 && m_pix != 2*R + 3; i++)
         applyStimulus(1'b1, 1'b0, rnd_pix(), 1'b0, 8'd0);
      applyStimulus(1'b1, 1'b1, 8'hA5, 1'b0, 8'd0);
      cmp("midsof_err", 32'(sof_err),     32'd1);
      cmp("midsof_val", 32'(bus.cen_val), 32'hA5);
      cmp("midsof_x",   32'(bus.cen_x),   32'd0);
      cmp("midsof_y",   32'(bus.cen_y),   32'd0);
      post_n = 0; done_seen = 0;
      for (int i = 0; i < 200 && !done_seen; i++) begin
         applyStimulus(1'b1, 1'b0, rnd_pix(), 1'b0, 8'd0);
         if (bus.cen_is_val) post_n++;
         if (frame_done) done_seen = 1;
      end
      cmp("midsof_done_seen", 32'(done_seen), 32'd1);
      cmp("midsof_post_vals", 32'(post_n),    32'd66);
      cmp("midsof_frame_cnt", 32'(frame_cnt), 32'd1);

      // Random gapped traffic with occasional stray SOFs and threshold writes.
      for (int i = 0; i < 900; i++) begin
         bit v, s, we;
         v  = ($urandom_range(0, 1) == 1);
         s  = (m_mode == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 150) == 0);
         we = ($urandom_range(0, 15) == 0);
         applyStimulus(v, s, 8'($urandom_range(0, 255)), we, 8'($urandom_range(0, 255)));
      end

      // Finish any frame in progress, start another and reset it during flush.
      for (int i = 0; i < 300 && m_mode != 0; i++)
         applyStimulus(1'b1, 1'b0, rnd_pix(), 1'b0, 8'd0);
      sof_pending = 1;
      for (int i = 0; i < 300 && !(m_mode == 2 && m_fl == 8); i++) begin
         acc = m_ready();
         applyStimulus(1'b1, sof_pending, rnd_pix(), 1'b0, 8'd0);
         if (acc) sof_pending = 0;
      end
      cmp("flrst_reached_flush_x", 32'(bus.cen_x),      32'd7);
      cmp("flrst_reached_flush_v", 32'(bus.cen_is_val), 32'd1);
      reset_n = 1'b0;
      model_reset();
      #1;
      cmp("flrst_ready",  32'(bus.src_ready),  32'd0);
      cmp("flrst_isval",  32'(bus.cen_is_val), 32'd0);
      cmp("flrst_val",    32'(bus.cen_val),    32'd0);
      cmp("flrst_x",      32'(bus.cen_x),      32'd0);
      cmp("flrst_y",      32'(bus.cen_y),      32'd0);
      cmp("flrst_thr",    32'(bus.cen_thresh), 32'd0);
      cmp("flrst_cenrst", 32'(bus.cen_reset),  32'd0);
      cmp("flrst_done",   32'(frame_done),     32'd0);
      cmp("flrst_err",    32'(sof_err),        32'd0);
      cmp("flrst_busy",   32'(busy),           32'd0);
      cmp("flrst_cnt",    32'(frame_cnt),      32'd0);
      repeat (2) applyStimulus(1'b1, 1'b0, rnd_pix(), 1'b0, 8'd0);
      reset_n = 1'b1;
      applyStimulus(1'b1, 1'b1, rnd_pix(), 1'b0, 8'd0);
      cmp("flrst_repulse",    32'(bus.cen_reset), 32'd1);
      applyStimulus(1'b1, 1'b1, rnd_pix(), 1'b0, 8'd0);
      cmp("flrst_pulse_end",  32'(bus.cen_reset), 32'd0);
      cmp("flrst_ready_after", 32'(bus.src_ready), 32'd1);
      cmp("flrst_cnt_after",  32'(frame_cnt),     32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/census_stream_ctrl.md
# census_stream_ctrl

Frame sequencer in front of the streaming census unit. It accepts raw 8-bit pixels from the camera capture path over a valid/ready handshake and generates the census unit's `in_x`/`in_y`/`is_in_val` stream, its sync reset and its threshold. At end of frame it drains the census line buffers by injecting flush pixels, so the last two rows of every frame reach the output. The frame-done pulse goes to the downstream disparity logic.

## Interface
- `ROW_SZ`, 320, pixels per row; must match the census unit.
- `COL_SZ`, 240, rows per frame; must match the census unit.
- `FLUSH_LEN`, 2*ROW_SZ+3, flush pixels injected after the last real pixel.

Ports:
- `clk`  in  1  single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `thresh_in`  in  8  staged census threshold.
- `thresh_we`  in  1  writes `thresh_in` into the staging register.
- `src_val`  in  8  pixel value.
- `src_valid`  in  1  pixel present.
- `src_sof`  in  1  start of frame; qualified by `src_valid`, marks pixel (0,0).
- `src_ready`  out  1  controller accepts a pixel this cycle.
- `cen_val`  out  8  pixel to census `in_val`.
- `cen_x`  out  10  to census `in_x`.
- `cen_y`  out  10  to census `in_y`.
- `cen_is_val`  out  1  to census `is_in_val`.
- `cen_thresh`  out  8  to census `thresh`.
- `cen_reset`  out  1  active-high sync reset to census.
- `frame_done`  out  1  one-cycle pulse after flush completes.
- `sof_err`  out  1  one-cycle pulse when SOF arrives mid-frame.
- `busy`  out  1  high in RUN or FLUSH.
- `frame_cnt`  out  16  completed frames; wraps modulo 2^16.

## Operation
- Acceptance is `src_valid & src_ready`.
- The state machine has four states: IDLE, RUN, FLUSH and DONE.

**IDLE**
- `src_ready`=1.
- Accepted pixels without `src_sof` are discarded.
- An accepted SOF pixel does the following:
  - emits (val, x=0, y=0) on the `cen_*` outputs;
  - copies the staging register into `cen_thresh`;
  - sets x=1, y=0;
  - moves to RUN.
- The first SOF after reset is preceded by `cen_reset`=1 for exactly one cycle, asserted in the first IDLE cycle after `reset_n` deasserts.
- The SOF pixel is accepted no earlier than the following cycle; `src_ready`=0 during the `cen_reset` cycle.

**RUN**
- `src_ready`=1.
- Each accepted pixel is emitted with the current x,y.
- x increments; at x=ROW_SZ-1, x wraps to 0 and y increments.
- Acceptance of (ROW_SZ-1, COL_SZ-1) moves to FLUSH with x=0, y=0 and the flush counter cleared.
- An accepted pixel with `src_sof` in RUN aborts the frame:
  - `sof_err` pulses;
  - the pixel is emitted as (0,0) and x=1, y=0;
  - the staging threshold is copied into `cen_thresh`;
  - the state stays RUN;
  - `frame_cnt` is unchanged.

**FLUSH**
- `src_ready`=0.
- The controller emits `cen_val`=0 with `cen_is_val`=1 every cycle, continuing the x/y sequence from (0,0) with the same wrap rule.
- After exactly FLUSH_LEN emissions it moves to DONE.

**DONE**
- Lasts one cycle.
- `frame_done`=1 and `frame_cnt` increments.
- `src_ready`=0.
- Next state is IDLE.

**Threshold and arithmetic rules**
- `thresh_we` updates only the staging register, in any state; `cen_thresh` changes only at frame start.
- If `thresh_we` and SOF acceptance coincide, the SOF takes the old staged value.
- x/y counters are 10 bits and compare with `==`; no value ≥ ROW_SZ/COL_SZ is ever emitted.

## Timing
- All outputs are registered.
- `cen_*` appear the cycle after acceptance (latency 1).
- `cen_is_val` is high for exactly one cycle per accepted or flush pixel.
- `src_ready` is a combinational function of state only, never of `src_valid`.
- Reset values, as async assertion of `reset_n`:
  - state=IDLE;
  - `src_ready`=0 until the `cen_reset` cycle has passed;
  - `cen_is_val`=0;
  - `cen_val`/`cen_x`/`cen_y`=0;
  - `cen_thresh`=0 and staging register=0;
  - `cen_reset`=0;
  - `frame_done`=`sof_err`=0;
  - `busy`=0;
  - `frame_cnt`=0.
- Reset mid-frame or mid-flush abandons the frame with no `frame_done`, then repeats the `cen_reset` pulse.
- Frame period is ROW_SZ*COL_SZ accepted pixels, plus FLUSH_LEN cycles, plus 1 DONE cycle, plus IDLE wait.

## Test plan
- **Reset, then a full frame:**
  - ROW_SZ=8, COL_SZ=6, FLUSH_LEN=19, `src_valid` held high, SOF on the first pixel.
  - Expect `cen_reset` for exactly one cycle before the SOF is accepted.
  - Expect 48 `cen_is_val` pulses with x 0..7 and y 0..5.
  - Expect 19 flush pulses with `cen_val`=0, running from (0,0) to (2,2).
  - Expect `frame_done` one cycle later and `frame_cnt`=1.
- **Gapped input:** `src_valid` toggles randomly → x/y sequence identical to the full-frame case; no `cen_is_val` without acceptance.
- **Mid-frame SOF:**
  - SOF at pixel (3,2).
  - Expect `sof_err` for one cycle and that pixel emitted as (0,0).
  - The frame then completes 48 pixels later; `frame_cnt`=1, not 2.
- **Threshold staging:**
  - Write 0x10 mid-frame → `cen_thresh` stays 0 until the next SOF, then 0x10.
  - Write coinciding with SOF → `cen_thresh` takes the old value.
- **Pre-SOF garbage:** 5 non-SOF pixels in IDLE → accepted (`src_ready`=1) with no `cen_is_val`; the next SOF starts at (0,0).
- **Async reset during FLUSH:**
  - Assert `reset_n`=0 at flush pixel 7.
  - All outputs go to their reset values immediately; no `frame_done`.
  - After release, `cen_reset` pulses again and `frame_cnt`=0.
